updown_counter_7seg: RTL and testbench

- Single-digit-pair up/down counter with a two-digit 7-segment display.
- An internal prescaler derives a count tick from the board clock.
- A 4-bit counter (0..15) steps up or down on each tick. Its value is split into tens/units and decoded to two active-low 7-segment outputs.
- Top-level of the lab board design; drives the two rightmost HEX displays directly.

---
 rtl/updown_counter_7seg.sv | 93 +++++++++
 tb/tb_updown_counter_7seg.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_7seg.sv
// updown_counter_7seg
//   A prescaler produces a one-cycle tick enable from the board clock. On each
//   tick a 4-bit value (0..15) steps up or down with wrap-around. The value is
//   split into tens and units digits, and each digit drives an active-low
//   7-segment display.
//
// Ports
//   clk      board clock, all state on its rising edge
//   rst      asynchronous reset, active-low
//   up       direction: 1 = increment, 0 = decrement (sampled on tick edges)
//   timer    rate select: 0 = tick every fpga_freq cycles, 1 = every fpga_freq/2
//   decsegm  tens-digit segments, active-low, bit0 = a ... bit6 = g
//   unisegm  units-digit segments, active-low, bit0 = a ... bit6 = g
module updown_counter_7seg #(
  parameter int fpga_freq = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       timer,
  output logic [6:0] decsegm,
  output logic [6:0] unisegm
);

  localparam int CntW = $clog2(fpga_freq);
  localparam logic [CntW-1:0] SlowLast = CntW'(fpga_freq - 1);
  localparam logic [CntW-1:0] FastLast = CntW'(fpga_freq / 2 - 1);

  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] periodLast;
  logic            tick;
  logic [3:0]      value_q, value_d;
  logic            isTens;
  logic [3:0]      tens, units;

  // Segment pattern for one decimal digit. Codes 10..15 cannot occur and blank.
  function automatic logic [6:0] decode7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Prescaler. The >= compare, rather than ==, means that switching to the
  // fast rate while the count already sits past the new terminal value fires
  // a tick on the next edge instead of running off to the top of the counter.
  // The tick is held low while reset is asserted.
  always_comb begin
    periodLast = timer ? FastLast : SlowLast;
    tick       = rst & (count_q >= periodLast);
    count_d    = tick ? '0 : count_q + CntW'(1);
  end

  // Value update, only on tick cycles; 4-bit arithmetic gives the 15<->0 wrap.
  always_comb begin
    value_d = value_q;
    if (tick) begin
      value_d = up ? value_q + 4'd1 : value_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      value_q <= 4'd0;
    end else begin
      count_q <= count_d;
      value_q <= value_d;
    end
  end

  // Tens/units split and decode, combinational from the value register so the
  // display changes in the same cycle as the tick edge.
  always_comb begin
    isTens  = (value_q >= 4'd10);
    tens    = isTens ? 4'd1 : 4'd0;
    units   = isTens ? value_q - 4'd10 : value_q;
    decsegm = decode7(tens);
    unisegm = decode7(units);
  end

endmodule

// File: tb/tb_updown_counter_7seg.sv
// tb_updown_counter_7seg
//   Directed bench for updown_counter_7seg with fpga_freq = 8 (slow tick every
//   8 edges, fast tick every 4 edges) and a 20 ns clock. Inputs change and
//   outputs are sampled on the falling edge.
module tb_updown_counter_7seg;

  logic       clk;
  logic       rst;
  logic       up;
  logic       timer;
  logic [6:0] decsegm;
  logic [6:0] unisegm;

  int vectors;
  int miscompares;

  updown_counter_7seg #(.fpga_freq(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .up     (up),
    .timer  (timer),
    .decsegm(decsegm),
    .unisegm(unisegm)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Expected {decsegm, unisegm} for a displayed value 0..15.
  function automatic logic [13:0] expSegs(input int v);
    logic [6:0] segTab [0:9];
    segTab[0] = 7'b1000000; segTab[1] = 7'b1111001;
    segTab[2] = 7'b0100100; segTab[3] = 7'b0110000;
    segTab[4] = 7'b0011001; segTab[5] = 7'b0010010;
    segTab[6] = 7'b0000010; segTab[7] = 7'b1111000;
    segTab[8] = 7'b0000000; segTab[9] = 7'b0010000;
    return {segTab[v / 10], segTab[v % 10]};
  endfunction

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Held in reset the display reads "00"; release lines up with a falling edge.
  task automatic test_reset();
    rst = 1'b0; up = 1'b1; timer = 1'b0;
    @(negedge clk);
    vectors++;
    if (decsegm !== 7'b1000000) begin
      miscompares++;
      $display("[TB] FAIL reset_dec: got %b expected %b", decsegm, 7'b1000000);
    end
    vectors++;
    if (unisegm !== 7'b1000000) begin
      miscompares++;
      $display("[TB] FAIL reset_uni: got %b expected %b", unisegm, 7'b1000000);
    end
    rst = 1'b1;
  endtask

  // No change on edges 1..7 after release, "01" after the 8th.
  task automatic test_first_tick();
    for (int i = 1; i <= 7; i++) begin
      edges(1);
      vectors++;
      if ({decsegm, unisegm} !== expSegs(0)) begin
        miscompares++;
        $display("[TB] FAIL first_tick_wait edge %0d: got %b_%b expected %b", i, decsegm, unisegm, expSegs(0));
      end
    end
    edges(1);
    vectors++;
    if ({decsegm, unisegm} !== expSegs(1)) begin
      miscompares++;
      $display("[TB] FAIL first_tick: got %b_%b expected %b", decsegm, unisegm, expSegs(1));
    end
  endtask

  // Count up through 9 -> 10 and 15 -> 0.
  task automatic test_count_up();
    for (int v = 2; v <= 16; v++) begin
      edges(8);
      vectors++;
      if ({decsegm, unisegm} !== expSegs(v % 16)) begin
        miscompares++;
        $display("[TB] FAIL count_up %0d: got %b_%b expected %b", v % 16, decsegm, unisegm, expSegs(v % 16));
      end
    end
  endtask

  // Count down from 0: 15, 14, 13.
  task automatic test_count_down();
    up = 1'b0;
    for (int v = 15; v >= 13; v--) begin
      edges(8);
      vectors++;
      if ({decsegm, unisegm} !== expSegs(v)) begin
        miscompares++;
        $display("[TB] FAIL count_down %0d: got %b_%b expected %b", v, decsegm, unisegm, expSegs(v));
      end
    end
  endtask

  // Fast rate from 13: unchanged after 3 edges, next value after the 4th.
  task automatic test_fast();
    int exp;
    timer = 1'b1; up = 1'b1;
    exp = 13;
    for (int k = 0; k < 3; k++) begin
      edges(3);
      vectors++;
      if ({decsegm, unisegm} !== expSegs(exp)) begin
        miscompares++;
        $display("[TB] FAIL fast_hold %0d: got %b_%b expected %b", exp, decsegm, unisegm, expSegs(exp));
      end
      exp = (exp + 1) % 16;
      edges(1);
      vectors++;
      if ({decsegm, unisegm} !== expSegs(exp)) begin
        miscompares++;
        $display("[TB] FAIL fast_tick %0d: got %b_%b expected %b", exp, decsegm, unisegm, expSegs(exp));
      end
    end
  endtask

  // Slow count reaches 6, then switching to fast ticks on the very next edge.
  task automatic test_timer_switch();
    timer = 1'b0;
    edges(6);
    vectors++;
    if ({decsegm, unisegm} !== expSegs(0)) begin
      miscompares++;
      $display("[TB] FAIL switch_hold: got %b_%b expected %b", decsegm, unisegm, expSegs(0));
    end
    timer = 1'b1;
    edges(1);
    vectors++;
    if ({decsegm, unisegm} !== expSegs(1)) begin
      miscompares++;
      $display("[TB] FAIL switch_tick: got %b_%b expected %b", decsegm, unisegm, expSegs(1));
    end
    edges(4);
    vectors++;
    if ({decsegm, unisegm} !== expSegs(2)) begin
      miscompares++;
      $display("[TB] FAIL switch_after: got %b_%b expected %b", decsegm, unisegm, expSegs(2));
    end
  endtask

  // Direction toggles between ticks; only the level at the tick edge matters.
  task automatic test_up_glitch();
    edges(1); up = 1'b0;
    edges(1); up = 1'b1;
    edges(2);
    vectors++;
    if ({decsegm, unisegm} !== expSegs(3)) begin
      miscompares++;
      $display("[TB] FAIL glitch_up: got %b_%b expected %b", decsegm, unisegm, expSegs(3));
    end
    up = 1'b0;
    edges(1); up = 1'b1;
    edges(1); up = 1'b0;
    edges(2);
    vectors++;
    if ({decsegm, unisegm} !== expSegs(2)) begin
      miscompares++;
      $display("[TB] FAIL glitch_down: got %b_%b expected %b", decsegm, unisegm, expSegs(2));
    end
  endtask

  // Asynchronous reset mid-period, then a full slow period before "01".
  task automatic test_reset_midcount();
    timer = 1'b0; up = 1'b1;
    edges(2);
    #3 rst = 1'b0;
    #1;
    vectors++;
    if ({decsegm, unisegm} !== expSegs(0)) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %b_%b expected %b", decsegm, unisegm, expSegs(0));
    end
    @(negedge clk);
    rst = 1'b1;
    edges(7);
    vectors++;
    if ({decsegm, unisegm} !== expSegs(0)) begin
      miscompares++;
      $display("[TB] FAIL rerelease_hold: got %b_%b expected %b", decsegm, unisegm, expSegs(0));
    end
    edges(1);
    vectors++;
    if ({decsegm, unisegm} !== expSegs(1)) begin
      miscompares++;
      $display("[TB] FAIL rerelease_tick: got %b_%b expected %b", decsegm, unisegm, expSegs(1));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b0;
    up    = 1'b1;
    timer = 1'b0;
    test_reset();
    test_first_tick();
    test_count_up();
    test_count_down();
    test_fast();
    test_timer_switch();
    test_up_glitch();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
